// File: rtl/c499_lock_pkg.sv
// Shared constants and state encoding for the c499 key-provisioning logic.
// The key is 17 XOR key-gate bits followed by 4 mux-select bits.
package c499_lock_pkg;

  localparam int XOR_W = 17;
  localparam int MUX_W = 4;
  localparam int KEY_W = XOR_W + MUX_W;
  localparam int CNT_W = 5;

  // Positions of the X_1..X_17 and p1..p4 fields inside the assembled key.
  localparam int X_LSB = 0;
  localparam int X_MSB = XOR_W - 1;
  localparam int P_LSB = XOR_W;
  localparam int P_MSB = KEY_W - 1;

  // Loader sequencing: IDLE -> SHIFT (key bits) -> PARITY -> COMMIT -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/c499_key_if.sv
// Serial key-load bus between the provisioning source and the key loader,
// plus the committed key outputs that go to the locked c499 netlist.
interface c499_key_if
  import c499_lock_pkg::*;
#(
  parameter int XW = XOR_W,
  parameter int MW = MUX_W
);

  logic          key_start;
  logic          key_bit_valid;
  logic          key_bit;
  logic          key_bit_ready;
  logic [XW-1:0] xor_key;
  logic [MW-1:0] mux_sel;
  logic          key_valid;
  logic          key_err;
  logic          busy;

  // Provisioning source: drives the serial stream, observes loader status.
  modport master (
    output key_start, key_bit_valid, key_bit,
    input  key_bit_ready, xor_key, mux_sel, key_valid, key_err, busy
  );

  // Key loader: consumes the serial stream, owns the committed key.
  modport slave (
    input  key_start, key_bit_valid, key_bit,
    output key_bit_ready, xor_key, mux_sel, key_valid, key_err, busy
  );

endinterface

// File: rtl/c499_key_loader.sv
// Serial loader for the c499 unlock key. Receives 21 key bits LSB first and
// a trailing even-parity bit, then commits the key to registered outputs.
// Outputs stay zero and key_valid stays low until a load passes parity.
module c499_key_loader
  import c499_lock_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  c499_key_if.slave   kif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               par_ok_q, par_ok_d;
  logic [XOR_W-1:0]   xor_key_q, xor_key_d;
  logic [MUX_W-1:0]   mux_sel_q, mux_sel_d;
  logic               key_valid_q, key_valid_d;
  logic               key_err_q, key_err_d;
  logic               busy_q, busy_d;

  logic               ready;
  logic               xfer;

  // Bits are accepted only while collecting key or parity bits; this depends
  // on registered state alone, so there is no input-to-output path.
  assign ready = (state_q == SHIFT) || (state_q == PARITY);
  assign xfer  = kif.key_bit_valid && ready;

  // Next-state and datapath logic for the load sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    par_ok_d    = par_ok_q;
    xor_key_d   = xor_key_q;
    mux_sel_d   = mux_sel_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    busy_d      = busy_q;

    if (kif.key_start) begin
      // A start pulse always begins a fresh load, from any state; a bit
      // presented in the same cycle is dropped and a pending commit is lost.
      state_d     = SHIFT;
      cnt_d       = '0;
      shreg_d     = '0;
      par_d       = 1'b0;
      par_ok_d    = 1'b0;
      xor_key_d   = '0;
      mux_sel_d   = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (xfer) begin
            shreg_d[cnt_q] = kif.key_bit;
            par_d          = par_q ^ kif.key_bit;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (xfer) begin
            par_ok_d = ~(par_q ^ kif.key_bit);
            state_d  = COMMIT;
          end
        end
        COMMIT: begin
          if (par_ok_q) begin
            xor_key_d   = shreg_q[X_MSB:X_LSB];
            mux_sel_d   = shreg_q[P_MSB:P_LSB];
            key_valid_d = 1'b1;
          end else begin
            key_err_d   = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          // IDLE: serial bits are ignored until the next start pulse.
        end
      endcase
    end
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset too, so a stale partial key can
      // never reach the outputs after an interrupted load.
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      par_ok_q    <= 1'b0;
      xor_key_q   <= '0;
      mux_sel_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      par_ok_q    <= par_ok_d;
      xor_key_q   <= xor_key_d;
      mux_sel_q   <= mux_sel_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      busy_q      <= busy_d;
    end
  end

  assign kif.key_bit_ready = ready;
  assign kif.xor_key       = xor_key_q;
  assign kif.mux_sel       = mux_sel_q;
  assign kif.key_valid     = key_valid_q;
  assign kif.key_err       = key_err_q;
  assign kif.busy          = busy_q;

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed self-checking bench for the c499 key loader. Inputs are driven
// right after the falling edge and outputs are sampled at the falling edge.
module tb_c499_key_loader;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  c499_key_if kif ();

  c499_key_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0x0A5A5A has ten set bits, so its even-parity bit is 0.
  localparam logic [20:0] KEY_A    = 21'h0A5A5A;
  localparam logic        PAR_A    = 1'b0;
  localparam logic [16:0] XOR_A    = 17'h05A5A;
  localparam logic [3:0]  MUX_A    = 4'h5;
  // 0x1FFFFF has 21 set bits, so its even-parity bit is 1.
  localparam logic [20:0] KEY_B    = 21'h1FFFFF;
  localparam logic        PAR_B    = 1'b1;
  localparam logic [16:0] XOR_B    = 17'h1FFFF;
  localparam logic [3:0]  MUX_B    = 4'hF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic pulse_start();
    kif.key_start = 1'b1;
    @(negedge clk);
    kif.key_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    kif.key_bit_valid = 1'b1;
    kif.key_bit       = b;
    @(negedge clk);
    kif.key_bit_valid = 1'b0;
    kif.key_bit       = 1'b0;
  endtask

  // Sends 21 key bits and the parity bit; optional 3-cycle gaps after the
  // given bit indices (-1 for none). Returns in the COMMIT cycle.
  task automatic send_key(input logic [20:0] key, input logic par,
                          input int gap_a, input int gap_b);
    logic [20:0] k;
    k = key;
    for (int i = 0; i < 21; i++) begin
      send_bit(k[i]);
      if (i == gap_a || i == gap_b) begin
        repeat (3) @(negedge clk);
        check("gap_ready", 32'(kif.key_bit_ready), 32'd1);
      end
    end
    send_bit(par);
    check("commit_cycle_valid", 32'(kif.key_valid), 32'd0);
    check("commit_cycle_busy", 32'(kif.busy), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [16:0] x,
                               input logic [3:0] m, input logic v, input logic e);
    check({tag, "_xor"},   32'(kif.xor_key),       32'(x));
    check({tag, "_mux"},   32'(kif.mux_sel),       32'(m));
    check({tag, "_valid"}, 32'(kif.key_valid),     32'(v));
    check({tag, "_err"},   32'(kif.key_err),       32'(e));
    check({tag, "_busy"},  32'(kif.busy),          32'd0);
    check({tag, "_ready"}, 32'(kif.key_bit_ready), 32'd0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    kif.key_start     = 1'b0;
    kif.key_bit_valid = 1'b0;
    kif.key_bit       = 1'b0;
    repeat (2) @(negedge clk);
    expect_result("reset", 17'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Serial bits while idle are ignored.
    send_bit(1'b1);
    send_bit(1'b1);
    expect_result("idle_ignore", 17'h0, 4'h0, 1'b0, 1'b0);

    // Good load of KEY_A; result appears one cycle after COMMIT.
    pulse_start();
    check("start_busy", 32'(kif.busy), 32'd1);
    check("start_ready", 32'(kif.key_bit_ready), 32'd1);
    send_key(KEY_A, PAR_A, -1, -1);
    @(negedge clk);
    expect_result("good_a", XOR_A, MUX_A, 1'b1, 1'b0);

    // Same key, wrong parity: error, outputs cleared.
    pulse_start();
    send_key(KEY_A, ~PAR_A, -1, -1);
    @(negedge clk);
    expect_result("bad_par", 17'h0, 4'h0, 1'b0, 1'b1);

    // Gaps after bit 5 and bit 20 must not change the result.
    pulse_start();
    send_key(KEY_A, PAR_A, 5, 20);
    @(negedge clk);
    expect_result("gaps", XOR_A, MUX_A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    expect_result("hold", XOR_A, MUX_A, 1'b1, 1'b0);

    // Restart after 10 bits, with a bit presented in the restart cycle.
    pulse_start();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    kif.key_start     = 1'b1;
    kif.key_bit_valid = 1'b1;
    kif.key_bit       = 1'b1;
    @(negedge clk);
    kif.key_start     = 1'b0;
    kif.key_bit_valid = 1'b0;
    kif.key_bit       = 1'b0;
    send_key(KEY_B, PAR_B, -1, -1);
    @(negedge clk);
    expect_result("restart_b", XOR_B, MUX_B, 1'b1, 1'b0);

    // Start with a key committed clears the outputs on that edge.
    pulse_start();
    check("clr_valid", 32'(kif.key_valid), 32'd0);
    check("clr_xor", 32'(kif.xor_key), 32'd0);
    check("clr_mux", 32'(kif.mux_sel), 32'd0);
    check("clr_busy", 32'(kif.busy), 32'd1);

    // Start during the COMMIT cycle abandons the commit.
    send_key(KEY_B, PAR_B, -1, -1);
    pulse_start();
    repeat (2) @(negedge clk);
    check("abandon_valid", 32'(kif.key_valid), 32'd0);
    check("abandon_xor", 32'(kif.xor_key), 32'd0);
    check("abandon_busy", 32'(kif.busy), 32'd1);
    check("abandon_ready", 32'(kif.key_bit_ready), 32'd1);

    // Asynchronous reset mid-SHIFT, between clock edges.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(kif.busy), 32'd0);
    check("arst_ready", 32'(kif.key_bit_ready), 32'd0);
    check("arst_valid", 32'(kif.key_valid), 32'd0);
    check("arst_xor", 32'(kif.xor_key), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_result("post_rst", 17'h0, 4'h0, 1'b0, 1'b0);

    // A full load still works after the reset.
    pulse_start();
    send_key(KEY_A, PAR_A, -1, -1);
    @(negedge clk);
    expect_result("after_rst", XOR_A, MUX_A, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
